// File: rtl/scr1_dpmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_dpmem_pkg
//  Description : Shared types, latency limits and byte-merge helper for the
//                dual-port pipelined TCM array.
//  Revision    : 1.0 - initial release
// ============================================================================
package scr1_dpmem_pkg;

    localparam int SCR1_DPMEM_LAT_MIN = 1;
    localparam int SCR1_DPMEM_LAT_MAX = 2;

    typedef enum logic [0:0] {
        SCR1_DPMEM_CLR = 1'b0,
        SCR1_DPMEM_RUN = 1'b1
    } type_scr1_dpmem_clr_fsm_e;

    // One byte lane of a write-over-read merge: enabled lanes take the new byte.
    function automatic logic [7:0] scr1_dpmem_merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scr1_dpmem_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_dpmem_rd_pipe
//  Description : Per-port read-return stage, one or two registers deep,
//                with synchronous squash of all pending returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_dpmem_rd_pipe
    import scr1_dpmem_pkg::*;
#(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [SCR1_WIDTH-1:0] in_data,
    output logic                  rvalid,
    output logic [SCR1_WIDTH-1:0] rdata
);

    localparam int LAT = (SCR1_RD_LAT >= SCR1_DPMEM_LAT_MAX) ? SCR1_DPMEM_LAT_MAX
                                                             : SCR1_DPMEM_LAT_MIN;

    logic                  r_vld1;
    logic [SCR1_WIDTH-1:0] r_dat1;

    // Data registers load only with a valid return so rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
        end else begin
            r_vld1 <= in_valid;
            if (in_valid) begin
                r_dat1 <= in_data;
            end
        end
    end

    generate
        if (LAT == SCR1_DPMEM_LAT_MAX) begin : g_lat2
            logic                  r_vld2;
            logic [SCR1_WIDTH-1:0] r_dat2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_dat2 <= r_dat1;
                    end
                end
            end

            assign rvalid = r_vld2;
            assign rdata  = r_dat2;
        end else begin : g_lat1
            assign rvalid = r_vld1;
            assign rdata  = r_dat1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/scr1_dp_memory_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : scr1_dp_memory_pipe
//  Description : Dual-port byte-enabled TCM array with 1/2-cycle read
//                latency and a byte-merge bypass for A-read/B-write collisions.
//                Optional power-up clear FSM: define SCR1_DPMEM_CLR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module scr1_dp_memory_pipe
    import scr1_dpmem_pkg::*;
#(
    parameter int SCR1_WIDTH  = 32,
    parameter int SCR1_SIZE   = 32'h00010000,
    parameter int SCR1_NBYTES = SCR1_WIDTH / 8,
    parameter int SCR1_RD_LAT = 1,
    parameter int SCR1_BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_req,
    input  logic [$clog2(SCR1_SIZE)-3:0]  a_addr,
    output logic                          a_ready,
    output logic                          a_rvalid,
    output logic [SCR1_WIDTH-1:0]         a_rdata,
    input  logic                          b_req,
    input  logic                          b_we,
    input  logic [SCR1_NBYTES-1:0]        b_be,
    input  logic [$clog2(SCR1_SIZE)-3:0]  b_addr,
    input  logic [SCR1_WIDTH-1:0]         b_wdata,
    output logic                          b_ready,
    output logic                          b_rvalid,
    output logic [SCR1_WIDTH-1:0]         b_rdata
);

    localparam int ADDR_W         = $clog2(SCR1_SIZE) - 2;
    localparam int RAM_SIZE_WORDS = 2 ** ADDR_W;

    logic [SCR1_WIDTH-1:0] r_mem [0:RAM_SIZE_WORDS-1];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

`ifdef SCR1_DPMEM_CLR_EN
    type_scr1_dpmem_clr_fsm_e r_state;
    type_scr1_dpmem_clr_fsm_e w_state_next;
    logic [ADDR_W-1:0]        r_clr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SCR1_DPMEM_CLR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == SCR1_DPMEM_CLR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCR1_DPMEM_CLR: begin
                if (r_clr_cnt == ADDR_W'(RAM_SIZE_WORDS - 1)) begin
                    w_state_next = SCR1_DPMEM_RUN;
                end
            end
            SCR1_DPMEM_RUN: w_state_next = SCR1_DPMEM_RUN;
            default:        w_state_next = SCR1_DPMEM_CLR;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        w_clr_we = 1'b0;
        case (r_state)
            SCR1_DPMEM_CLR: w_clr_we = ~rst;
            SCR1_DPMEM_RUN: w_ready  = ~rst;
            default: begin
                w_ready  = 1'b0;
                w_clr_we = 1'b0;
            end
        endcase
    end

    assign w_clr_addr = r_clr_cnt;
`else
    assign w_ready    = ~rst;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign a_ready = w_ready;
    assign b_ready = w_ready;

    logic w_a_rd;
    logic w_b_rd;
    logic w_b_wr;
    logic w_coll;

    assign w_a_rd = a_req & w_ready;
    assign w_b_rd = b_req & w_ready & ~b_we;
    assign w_b_wr = b_req & w_ready & b_we;
    assign w_coll = w_a_rd & w_b_wr & (a_addr == b_addr);

    logic [SCR1_WIDTH-1:0] w_a_old;
    logic [SCR1_WIDTH-1:0] w_a_merged;
    logic [SCR1_WIDTH-1:0] w_a_word;
    logic [SCR1_WIDTH-1:0] w_b_word;

    assign w_a_old  = r_mem[a_addr];
    assign w_b_word = r_mem[b_addr];

    generate
        for (genvar i = 0; i < SCR1_NBYTES; i++) begin : g_lane
            assign w_a_merged[i*8 +: 8] = scr1_dpmem_merge_byte(w_a_old[i*8 +: 8],
                                                               b_wdata[i*8 +: 8],
                                                               b_be[i]);
        end

        if (SCR1_BYPASS != 0) begin : g_bypass
            assign w_a_word = w_coll ? w_a_merged : w_a_old;
        end else begin : g_no_bypass
            assign w_a_word = w_a_old;
        end
    endgenerate

    // Clear has priority; requests cannot be accepted while it runs anyway.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_b_wr) begin
            for (int i = 0; i < SCR1_NBYTES; i++) begin
                if (b_be[i]) begin
                    r_mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
                end
            end
        end
    end

    scr1_dpmem_rd_pipe #(
        .SCR1_WIDTH  (SCR1_WIDTH),
        .SCR1_RD_LAT (SCR1_RD_LAT)
    ) u_rd_pipe_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_a_rd),
        .in_data  (w_a_word),
        .rvalid   (a_rvalid),
        .rdata    (a_rdata)
    );

    scr1_dpmem_rd_pipe #(
        .SCR1_WIDTH  (SCR1_WIDTH),
        .SCR1_RD_LAT (SCR1_RD_LAT)
    ) u_rd_pipe_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (w_b_rd),
        .in_data  (w_b_word),
        .rvalid   (b_rvalid),
        .rdata    (b_rdata)
    );

endmodule
`default_nettype wire
